// File: rtl/serial_sub_pkg.sv
// Shared definitions for the bit-serial subtractor: FSM state encoding.
package serial_sub_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } sub_state_t;

endpackage : serial_sub_pkg

// File: rtl/full_subtractor_bit.sv
// One-bit full subtractor cell: d = x - y - bin, with borrow out.
module full_subtractor_bit (
  input  logic x,
  input  logic y,
  input  logic bin,
  output logic d,
  output logic bout
);

  assign d    = x ^ y ^ bin;
  assign bout = (~x & y) | (~(x ^ y) & bin);

endmodule : full_subtractor_bit

// File: rtl/serial_subtractor.sv
// Bit-serial unsigned subtractor (LSB first) with start/busy/done handshake.
// Optional signed-overflow flag on port ovf when SERIAL_SUB_OVERFLOW_EN is defined.
module serial_subtractor
  import serial_sub_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             borrow_out
`ifdef SERIAL_SUB_OVERFLOW_EN
  ,
  output logic             ovf
`endif
);

  localparam int CNT_W = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

  sub_state_t       state_q, state_d;
  logic [WIDTH-1:0] a_sr_q, a_sr_d;
  logic [WIDTH-1:0] b_sr_q, b_sr_d;
  logic [WIDTH-2:0] dsr_q, dsr_d;
  logic             borrow_q, borrow_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] diff_q, diff_d;
  logic             borrow_out_q, borrow_out_d;
`ifdef SERIAL_SUB_OVERFLOW_EN
  logic             ovf_q, ovf_d;
`endif

  logic             bit_d;
  logic             bit_bo;
  logic [WIDTH-1:0] shifted;

  full_subtractor_bit u_fs (
    .x   (a_sr_q[0]),
    .y   (b_sr_q[0]),
    .bin (borrow_q),
    .d   (bit_d),
    .bout(bit_bo)
  );

  // Earlier result bits sit in dsr_q; the current bit lands on top.
  assign shifted = {bit_d, dsr_q};

  always_comb begin
    // NOTE: every signal gets its hold value first so no path infers a latch.
    state_d      = state_q;
    a_sr_d       = a_sr_q;
    b_sr_d       = b_sr_q;
    dsr_d        = dsr_q;
    borrow_d     = borrow_q;
    cnt_d        = cnt_q;
    diff_d       = diff_q;
    borrow_out_d = borrow_out_q;
`ifdef SERIAL_SUB_OVERFLOW_EN
    ovf_d        = ovf_q;
`endif

    unique case (state_q)
      IDLE: begin
        if (start) begin
          a_sr_d   = a;
          b_sr_d   = b;
          dsr_d    = '0;
          borrow_d = 1'b0;
          cnt_d    = '0;
          state_d  = SHIFT;
        end
      end
      SHIFT: begin
        a_sr_d   = a_sr_q >> 1;
        b_sr_d   = b_sr_q >> 1;
        dsr_d    = shifted[WIDTH-1:1];
        borrow_d = bit_bo;
        cnt_d    = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_LAST) begin
          // Final bit: the operand LSBs now hold the original MSBs.
          diff_d       = shifted;
          borrow_out_d = bit_bo;
`ifdef SERIAL_SUB_OVERFLOW_EN
          ovf_d        = (a_sr_q[0] ^ b_sr_q[0]) & (a_sr_q[0] ^ bit_d);
`endif
          cnt_d        = cnt_q;
          state_d      = DONE;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      a_sr_q       <= '0;
      b_sr_q       <= '0;
      dsr_q        <= '0;
      borrow_q     <= 1'b0;
      cnt_q        <= '0;
      diff_q       <= '0;
      borrow_out_q <= 1'b0;
`ifdef SERIAL_SUB_OVERFLOW_EN
      ovf_q        <= 1'b0;
`endif
    end else begin
      state_q      <= state_d;
      a_sr_q       <= a_sr_d;
      b_sr_q       <= b_sr_d;
      dsr_q        <= dsr_d;
      borrow_q     <= borrow_d;
      cnt_q        <= cnt_d;
      diff_q       <= diff_d;
      borrow_out_q <= borrow_out_d;
`ifdef SERIAL_SUB_OVERFLOW_EN
      ovf_q        <= ovf_d;
`endif
    end
  end

  assign busy       = (state_q == SHIFT);
  assign done       = (state_q == DONE);
  assign diff       = diff_q;
  assign borrow_out = borrow_out_q;
`ifdef SERIAL_SUB_OVERFLOW_EN
  assign ovf        = ovf_q;
`endif

endmodule : serial_subtractor

// File: tb/tb_serial_subtractor.sv
// Self-checking bench: transaction-level model for WIDTH=8, exhaustive WIDTH=2 sweep.
module tb_serial_subtractor;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic [7:0] a = '0;
  logic [7:0] b = '0;
  logic       busy, done, borrow_out;
  logic [7:0] diff;

  logic       start2 = 1'b0;
  logic [1:0] a2 = '0;
  logic [1:0] b2 = '0;
  logic       busy2, done2, bo2;
  logic [1:0] diff2;
`ifdef SERIAL_SUB_OVERFLOW_EN
  logic       ovf, ovf2;
`endif

  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  serial_subtractor #(.WIDTH(8)) u_dut (
    .clk(clk), .rst_n(rst_n), .start(start), .a(a), .b(b),
    .busy(busy), .done(done), .diff(diff), .borrow_out(borrow_out)
`ifdef SERIAL_SUB_OVERFLOW_EN
    , .ovf(ovf)
`endif
  );

  serial_subtractor #(.WIDTH(2)) u_dut2 (
    .clk(clk), .rst_n(rst_n), .start(start2), .a(a2), .b(b2),
    .busy(busy2), .done(done2), .diff(diff2), .borrow_out(bo2)
`ifdef SERIAL_SUB_OVERFLOW_EN
    , .ovf(ovf2)
`endif
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Transaction model: m_k counts cycles remaining in the current job
  // (WIDTH+1 after accept, busy while >=2, result published when it reaches 1).
  int         m_k = 0;
  logic [7:0] m_ca = '0, m_cb = '0, m_diff = '0;
  logic       m_bo = 1'b0, m_ovf = 1'b0;

  always @(posedge clk) begin
    if (!rst_n) begin
      m_k = 0; m_diff = '0; m_bo = 1'b0; m_ovf = 1'b0;
    end else if (m_k == 0) begin
      if (start) begin
        m_k = 9; m_ca = a; m_cb = b;
      end
    end else begin
      m_k--;
      if (m_k == 1) begin
        int sd;
        m_diff = m_ca - m_cb;
        m_bo   = (m_ca < m_cb);
        sd     = int'($signed(m_ca)) - int'($signed(m_cb));
        m_ovf  = (sd > 127) || (sd < -128);
      end
    end
  end

  always @(negedge clk) begin
    check("busy", busy, m_k >= 2);
    check("done", done, m_k == 1);
    check("diff", diff, m_diff);
    check("borrow", borrow_out, m_bo);
`ifdef SERIAL_SUB_OVERFLOW_EN
    check("ovf", ovf, m_ovf);
`endif
  end

  // Called on the first negedge after an accept; returns at the done cycle.
  task automatic wait_done(output int busy_n, output int cyc);
    cyc = 1;
    busy_n = 0;
    while (cyc <= 24 && !done) begin
      if (busy) busy_n++;
      @(negedge clk);
      cyc++;
    end
    if (!done) cyc = -1;
  endtask

  task automatic run_op(input logic [7:0] ia, input logic [7:0] ib,
                        output int busy_n, output int cyc);
    @(negedge clk);
    a = ia; b = ib; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_done(busy_n, cyc);
  endtask

  initial begin
    int bc, dc, nd;
    repeat (3) @(negedge clk);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_diff", diff, 0);
    check("rst_borrow", borrow_out, 0);
    rst_n = 1'b1;

    run_op(8'h05, 8'h03, bc, dc);
    check("lat_busy_cycles", bc, 8);
    check("lat_done_cycle", dc, 9);
    check("d_05_03", diff, 8'h02);
    check("b_05_03", borrow_out, 0);
    run_op(8'h03, 8'h05, bc, dc);
    check("d_03_05", diff, 8'hFE);
    check("b_03_05", borrow_out, 1);
    run_op(8'h00, 8'h00, bc, dc);
    check("d_00_00", diff, 8'h00);
    check("b_00_00", borrow_out, 0);
    run_op(8'h5A, 8'h5A, bc, dc);
    check("d_eq", diff, 8'h00);
    check("b_eq", borrow_out, 0);
    run_op(8'hC3, 8'h00, bc, dc);
    check("d_b0", diff, 8'hC3);
    check("b_b0", borrow_out, 0);
`ifdef SERIAL_SUB_OVERFLOW_EN
    run_op(8'h80, 8'h01, bc, dc);
    check("d_80_01", diff, 8'h7F);
    check("ovf_80_01", ovf, 1);
    run_op(8'h7F, 8'h01, bc, dc);
    check("d_7f_01", diff, 8'h7E);
    check("ovf_7f_01", ovf, 0);
`endif

    // Start held high through a run; operand change after capture is ignored.
    @(negedge clk);
    a = 8'hFF; b = 8'h01; start = 1'b1;
    @(negedge clk);
    a = 8'h11;
    wait_done(bc, dc);
    check("held_done_seen", dc > 0, 1);
    check("held_diff", diff, 8'hFE);
    @(negedge clk);
    check("held_idle_not_busy", busy, 0);
    @(negedge clk);
    start = 1'b0;
    check("held_second_accept", busy, 1);
    wait_done(bc, dc);
    check("held2_done_cycle", dc, 9);
    check("held2_diff", diff, 8'h10);

    // Reset during SHIFT aborts with no done pulse.
    @(negedge clk);
    a = 8'h5A; b = 8'h33; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    check("abort_busy", busy, 0);
    check("abort_done", done, 0);
    check("abort_diff", diff, 0);
    rst_n = 1'b1;
    nd = 0;
    repeat (12) begin
      @(negedge clk);
      if (done) nd++;
    end
    check("abort_no_done", nd, 0);

    // WIDTH=2 exhaustive sweep.
    for (int i = 0; i < 4; i++) begin
      for (int j = 0; j < 4; j++) begin
        int c2;
        @(negedge clk);
        a2 = 2'(i); b2 = 2'(j); start2 = 1'b1;
        @(negedge clk);
        start2 = 1'b0;
        c2 = 0;
        while (c2 < 10 && !done2) begin
          @(negedge clk);
          c2++;
        end
        check($sformatf("w2_done_%0d_%0d", i, j), done2, 1);
        check($sformatf("w2_diff_%0d_%0d", i, j), diff2, (i - j) & 3);
        check($sformatf("w2_borrow_%0d_%0d", i, j), bo2, i < j);
      end
    end

    // Random traffic: stray starts, operand churn and occasional resets.
    for (int n = 0; n < 40; n++) begin
      int gap;
      @(negedge clk);
      a = 8'($urandom); b = 8'($urandom); start = 1'b1;
      @(negedge clk);
      start = 1'($urandom_range(0, 1));
      a = 8'($urandom); b = 8'($urandom);
      gap = $urandom_range(4, 14);
      for (int c = 0; c < gap; c++) begin
        @(negedge clk);
        start = ($urandom_range(0, 3) == 0);
        rst_n = ($urandom_range(0, 29) != 0);
      end
      @(negedge clk);
      rst_n = 1'b1; start = 1'b0;
    end
    repeat (12) @(negedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule : tb_serial_subtractor
